// File: rtl/conv_frame_sequencer_pkg.sv
// Shared types and sizing helpers for the conv frame sequencer slice.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } seq_state_e;

    localparam int DEF_IMG_WIDTH  = 4;
    localparam int DEF_IMG_HEIGHT = 4;
    localparam int FRAME_PIX      = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

    // Bits needed to hold every value 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// Buffer and datapath signals between the frame sequencer and its surroundings.
interface conv_frame_sequencer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 24,
    parameter int NUM_CHANNELS = 3,
    parameter int NUM_OUTPUTS  = 4,
    parameter int ADDR_WIDTH   = 16
);
    logic                                rd_en;
    logic [ADDR_WIDTH-1:0]               rd_addr;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]  rd_data;
    logic                                core_clr;
    logic                                pix_valid;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]  pix_data;
    logic                                res_valid;
    logic [NUM_OUTPUTS*RESULT_WIDTH-1:0] res_data;
    logic                                wr_en;
    logic [ADDR_WIDTH-1:0]               wr_addr;
    logic [NUM_OUTPUTS*RESULT_WIDTH-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, core_clr, pix_valid, pix_data, wr_en, wr_addr, wr_data,
        input  rd_data, res_valid, res_data
    );

    modport slave (
        input  rd_en, rd_addr, core_clr, pix_valid, pix_data, wr_en, wr_addr, wr_data,
        output rd_data, res_valid, res_data
    );
endinterface

// File: rtl/seq_result_writer.sv
// Captures pooled results into the output buffer, counts them and flags overflow.
module seq_result_writer
    import conv_seq_pkg::*;
#(
    parameter int RESULT_WIDTH = 24,
    parameter int NUM_OUTPUTS  = 4,
    parameter int POOL_OUTS    = 1,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr,
    input  logic                                active,
    input  logic [ADDR_WIDTH-1:0]               out_base,
    input  logic                                res_valid,
    input  logic [NUM_OUTPUTS*RESULT_WIDTH-1:0] res_data,
    output logic                                wr_en,
    output logic [ADDR_WIDTH-1:0]               wr_addr,
    output logic [NUM_OUTPUTS*RESULT_WIDTH-1:0] wr_data,
    output logic                                all_captured,
    output logic                                err_overflow
);
    localparam int OW = cnt_width(POOL_OUTS);

    logic [OW-1:0]                       out_cnt_q, out_cnt_d;
    logic                                wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]               wr_addr_q, wr_addr_d;
    logic [NUM_OUTPUTS*RESULT_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                                ovf_q, ovf_d;

    always_comb begin
        out_cnt_d = out_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
        if (clr) begin
            out_cnt_d = '0;
            ovf_d     = 1'b0;
        end else if (active && res_valid) begin
            // Results beyond the expected count are dropped, never written.
            if (int'(out_cnt_q) < POOL_OUTS) begin
                wr_en_d   = 1'b1;
                wr_addr_d = out_base + ADDR_WIDTH'(out_cnt_q);
                wr_data_d = res_data;
                out_cnt_d = out_cnt_q + OW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            out_cnt_q <= out_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign all_captured = (int'(out_cnt_q) >= POOL_OUTS);
    assign err_overflow = ovf_q;
endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller: clears the datapath, streams one frame in, waits for pooled results.
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int RESULT_WIDTH  = 24,
    parameter int IMG_WIDTH     = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT    = DEF_IMG_HEIGHT,
    parameter int NUM_CHANNELS  = 3,
    parameter int NUM_OUTPUTS   = 4,
    parameter int POOL_OUTS     = 1,
    parameter int ADDR_WIDTH    = 16,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   hold,
    input  logic [ADDR_WIDTH-1:0]  in_base,
    input  logic [ADDR_WIDTH-1:0]  out_base,
    conv_frame_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err_timeout,
    output logic                   err_overflow
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int PW   = cnt_width(NPIX);
    localparam int IW   = cnt_width(DRAIN_TIMEOUT);

    seq_state_e            state_q, state_d;
    logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
    logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  core_clr_q, core_clr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_to_q, err_to_d;

    logic                  start_accept;
    logic                  rd_en;
    logic                  all_captured;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] pix_word;

    assign start_accept = (state_q == IDLE) && start;
    assign rd_en        = (state_q == FEED) && !hold;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        idle_d     = idle_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        err_to_d   = err_to_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CLEAR;
                    in_base_d  = in_base;
                    out_base_d = out_base;
                    pix_cnt_d  = '0;
                    idle_d     = '0;
                    err_to_d   = 1'b0;
                end
            end
            CLEAR: state_d = FEED;
            FEED: begin
                if (rd_en) begin
                    pix_cnt_d = pix_cnt_q + PW'(1);
                    if (pix_cnt_q == PW'(NPIX - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.res_valid)                      idle_d = '0;
                else if (idle_q != IW'(DRAIN_TIMEOUT))  idle_d = idle_q + IW'(1);
                // A result arriving on the timeout cycle resets the counter, so capture wins.
                if (all_captured) begin
                    state_d = DONE;
                end else if (!bus.res_valid && idle_d == IW'(DRAIN_TIMEOUT)) begin
                    state_d  = DONE;
                    err_to_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                idle_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        pix_valid_d = rd_en;
        core_clr_d  = (state_d == CLEAR);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pix_cnt_q   <= '0;
            idle_q      <= '0;
            in_base_q   <= '0;
            out_base_q  <= '0;
            pix_valid_q <= 1'b0;
            core_clr_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            idle_q      <= idle_d;
            in_base_q   <= in_base_d;
            out_base_q  <= out_base_d;
            pix_valid_q <= pix_valid_d;
            core_clr_q  <= core_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_to_q    <= err_to_d;
        end
    end

    logic                                wr_en_w;
    logic [ADDR_WIDTH-1:0]               wr_addr_w;
    logic [NUM_OUTPUTS*RESULT_WIDTH-1:0] wr_data_w;

    seq_result_writer #(
        .RESULT_WIDTH(RESULT_WIDTH),
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .POOL_OUTS   (POOL_OUTS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_writer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (start_accept),
        .active      (state_q != IDLE),
        .out_base    (out_base_q),
        .res_valid   (bus.res_valid),
        .res_data    (bus.res_data),
        .wr_en       (wr_en_w),
        .wr_addr     (wr_addr_w),
        .wr_data     (wr_data_w),
        .all_captured(all_captured),
        .err_overflow(err_overflow)
    );

    // Read data arrives one cycle after rd_en, aligned with the delayed pix_valid.
    assign pix_word      = bus.rd_data;
    assign bus.pix_data  = pix_word;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = in_base_q + ADDR_WIDTH'(pix_cnt_q);
    assign bus.core_clr  = core_clr_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.wr_en     = wr_en_w;
    assign bus.wr_addr   = wr_addr_w;
    assign bus.wr_data   = wr_data_w;

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_to_q;
endmodule
